co2_level_filter: RTL and testbench
===================================

# co2_level_filter

Sensor front-end stage directly upstream of the vehicular emissions FSM. It accepts raw CO2 sensor samples and computes a moving average over a power-of-two window. The result is scaled to the 8-bit `CO2_level` domain that the emissions FSM consumes. It also flags a stalled sensor, so that a frozen reading is not treated as a valid level.

## Interface

Parameters:
- `SAMPLE_W`, default 10: raw sample width. Must be 8 or more.
- `LOG2_WIN`, default 2: log2 of the averaging window. Window `WIN = 2**LOG2_WIN`; legal range 1..4.
- `TIMEOUT`, default 1000: number of idle cycles, counted from the last accepted sample, before a fault is raised. Must be 2 or more.

Ports:
- `clk` input 1: the single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `sample_valid` input 1: a sample is presented this cycle. It is always accepted; there is no backpressure.
- `sample_data` input `SAMPLE_W`: raw sensor reading, unsigned.
- `co2_level` output 8: filtered level. Registered; holds its value between updates.
- `level_valid` output 1: one-cycle pulse, high when `co2_level` has just been updated.
- `window_full` output 1: high while the window holds `WIN` valid samples.
- `sensor_fault` output 1: sensor stall detected.

## Operation

Storage:
- Circular buffer of `WIN` x `SAMPLE_W` entries.
- Write pointer `wr_ptr` of `LOG2_WIN` bits, wrapping from `WIN-1` to 0.
- Running sum `sum` of `SAMPLE_W+LOG2_WIN` bits; it can never overflow.

On each accepted sample:
- `sum <= sum + sample_data - buf[wr_ptr]`.
- `buf[wr_ptr] <= sample_data`.
- `wr_ptr <= wr_ptr + 1`.
- During FILL, `buf` entries are zero, so the subtracted value is 0.

Scaling:
- `avg = sum_next >> LOG2_WIN`, `SAMPLE_W` bits, truncating.
- `co2_level = avg[SAMPLE_W-1 -: 8]`, i.e. the top 8 bits. Identity when `SAMPLE_W` is 8.

State machine (binary-encoded states FILL, RUN, FAULT):
- **FILL** (reset state):
  - Counts accepted samples.
  - `co2_level` and `level_valid` are not updated.
  - The `WIN`-th accepted sample moves the FSM to RUN, updates `co2_level`, and pulses `level_valid`.
- **RUN:**
  - Every accepted sample updates `co2_level` and pulses `level_valid`.
  - `window_full` = 1.
- **FAULT:**
  - `sensor_fault` = 1; `co2_level` holds its last value; no `level_valid` pulses.
  - The next accepted sample clears `buf` and `sum`, sets `wr_ptr` to 0, and then loads that sample as sample 1 of a new FILL.
  - `sensor_fault` and `window_full` go to 0.

Idle counter:
- Cleared on every accepted sample and on reset; otherwise increments, saturating at `TIMEOUT`.
- Reaching `TIMEOUT` in FILL or RUN causes the move to FAULT.

Reset values:
- `co2_level` = 0, `level_valid` = 0, `window_full` = 0, `sensor_fault` = 0.
- State FILL, `sum` = 0, `buf` all 0, `wr_ptr` = 0, idle counter 0.

Reset asserted mid-operation discards all samples. After reset, `WIN` new samples are required before the next `level_valid`.

## Timing

- Latency: `sample_valid` sampled at edge k gives `co2_level`/`level_valid` visible after edge k, with registered outputs. One-cycle latency.
- Back-to-back samples on consecutive cycles are supported; `level_valid` is then high on consecutive cycles.
- `window_full` rises together with the first `level_valid`.
- Fault timing: with the last accepted sample at edge k and no `sample_valid` at edges k+1..k+TIMEOUT, `sensor_fault` = 1 after edge k+TIMEOUT.
- `sample_valid` at edge k+TIMEOUT wins: the sample is accepted and no fault is raised.
- After reset, the idle counter runs immediately, so a sensor that never reports faults after `TIMEOUT` cycles.
- `reset` has priority over `sample_valid` in the same cycle; that sample is dropped.

## Configuration

- `CO2_FAULT_TIMEOUT_EN` defined:
  - The idle counter, the FAULT state and the timeout behaviour described above are compiled in.
- Not defined:
  - No idle counter and no FAULT state; the FSM is FILL/RUN only.
  - `sensor_fault` is tied to 0.
  - `TIMEOUT` is ignored.
  - All other behaviour is identical.

## Test plan

All scenarios use `SAMPLE_W`=10 and `LOG2_WIN`=2; scenarios 4 and 5 use `TIMEOUT`=16; the macro is defined unless stated.

1. Fill: reset, then samples 400, 400, 400, 400 on consecutive cycles -> no `level_valid` for the first three; after the 4th, `level_valid`=1, `co2_level`=100, `window_full`=1.
2. Slide: continue from 1 with sample 800 -> `sum`=2000, `co2_level`=125, `level_valid` pulse; the next idle cycle gives `level_valid`=0 with `co2_level` held at 125.
3. Full scale: four samples of 1023 -> `co2_level`=255 and no wrap. Then four samples of 0 -> `co2_level` sequence 191, 127, 63, 0.
4. Timeout boundary: in RUN, 16 idle cycles -> `sensor_fault`=1 and `co2_level` held. Repeat with `sample_valid` on the 16th idle edge -> no fault.
5. Fault recovery: in FAULT, send samples 200 x4 -> `sensor_fault`=0 and `window_full`=0 after the first; `level_valid` only after the 4th, with `co2_level`=50.
6. Reset mid-RUN: one-cycle `reset` coincident with `sample_valid` -> all outputs 0 next cycle, and exactly 4 further samples are needed for `level_valid`. Repeat with the macro undefined -> `sensor_fault` is never 1 after 5000 idle cycles.

Source files
------------

// File: rtl/co2_level_filter.sv
// CO2 sensor front-end: power-of-two moving average scaled to 8 bits, with stall detection.
// Optional feature macro: CO2_FAULT_TIMEOUT_EN compiles in the idle counter and FAULT state.
module co2_level_filter #(
  parameter int unsigned SAMPLE_W = 10,
  parameter int unsigned LOG2_WIN = 2,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic [7:0]          co2_level,
  output logic                level_valid,
  output logic                window_full,
  output logic                sensor_fault
);

  localparam int unsigned Win  = 2 ** LOG2_WIN;
  localparam int unsigned SumW = SAMPLE_W + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] PtrLast = LOG2_WIN'(Win - 1);

  if (SAMPLE_W < 8 || LOG2_WIN < 1 || LOG2_WIN > 4 || TIMEOUT < 2) begin : g_param_check
    $error("co2_level_filter: illegal parameter value");
  end

`ifdef CO2_FAULT_TIMEOUT_EN
  typedef enum logic [1:0] {StFill, StRun, StFault} state_e;
`else
  typedef enum logic [0:0] {StFill, StRun} state_e;
`endif

  state_e state_q, state_d;

  logic [SAMPLE_W-1:0] buf_q [Win];
  logic [SAMPLE_W-1:0] buf_d [Win];
  logic [LOG2_WIN-1:0] wr_ptr_q, wr_ptr_d;
  logic [SumW-1:0]     sum_q, sum_d;
  logic [7:0]          co2_level_q, co2_level_d;
  logic                level_valid_q, level_valid_d;
  logic                window_full_q, window_full_d;

  logic                timeout_hit;
  logic                restart;
  logic                fill_done;

`ifdef CO2_FAULT_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  logic [IdleW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (sample_valid) begin
      idle_d = '0;
    end else if (idle_q != IdleW'(TIMEOUT)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  // Fault is raised on the same edge the counter reaches TIMEOUT.
  assign timeout_hit  = !sample_valid && (idle_q == IdleW'(TIMEOUT - 1));
  assign restart      = (state_q == StFault);
  assign sensor_fault = (state_q == StFault);
`else
  assign timeout_hit  = 1'b0;
  assign restart      = 1'b0;
  assign sensor_fault = 1'b0;
`endif

  // FILL always starts from wr_ptr 0, so the pointer doubles as the fill count.
  assign fill_done = sample_valid && (state_q == StFill) && (wr_ptr_q == PtrLast);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: begin
        if (fill_done) begin
          state_d = StRun;
        end else if (timeout_hit) begin
`ifdef CO2_FAULT_TIMEOUT_EN
          state_d = StFault;
`endif
        end
      end
      StRun: begin
        if (timeout_hit) begin
`ifdef CO2_FAULT_TIMEOUT_EN
          state_d = StFault;
`endif
        end
      end
`ifdef CO2_FAULT_TIMEOUT_EN
      StFault: begin
        if (sample_valid) begin
          state_d = StFill;
        end
      end
`endif
      default: state_d = StFill;
    endcase
  end

  // Datapath and output next-state logic
  logic [LOG2_WIN-1:0] ptr;
  logic [SAMPLE_W-1:0] sub;
  logic [SumW-1:0]     sum_base;
  logic [SumW-1:0]     sum_next;
  logic [7:0]          avg_top;

  always_comb begin
    ptr      = restart ? '0 : wr_ptr_q;
    sub      = restart ? '0 : buf_q[wr_ptr_q];
    sum_base = restart ? '0 : sum_q;
    sum_next = sum_base + SumW'(sample_data) - SumW'(sub);
    // Top 8 bits of (sum_next >> LOG2_WIN) truncated to SAMPLE_W bits.
    avg_top  = sum_next[SumW-1 -: 8];

    buf_d         = buf_q;
    wr_ptr_d      = wr_ptr_q;
    sum_d         = sum_q;
    co2_level_d   = co2_level_q;
    level_valid_d = 1'b0;
    window_full_d = window_full_q;

    if (sample_valid) begin
      if (restart) begin
        buf_d         = '{default: '0};
        window_full_d = 1'b0;
      end
      buf_d[ptr] = sample_data;
      wr_ptr_d   = ptr + 1'b1;
      sum_d      = sum_next;
      if (state_q == StRun || fill_done) begin
        co2_level_d   = avg_top;
        level_valid_d = 1'b1;
        window_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      sum_q         <= '0;
      co2_level_q   <= '0;
      level_valid_q <= 1'b0;
      window_full_q <= 1'b0;
    end else begin
      buf_q         <= buf_d;
      wr_ptr_q      <= wr_ptr_d;
      sum_q         <= sum_d;
      co2_level_q   <= co2_level_d;
      level_valid_q <= level_valid_d;
      window_full_q <= window_full_d;
    end
  end

  assign co2_level   = co2_level_q;
  assign level_valid = level_valid_q;
  assign window_full = window_full_q;

endmodule

// File: tb/tb_co2_level_filter.sv
// Directed self-checking bench for co2_level_filter (SAMPLE_W=10, LOG2_WIN=2, TIMEOUT=16).
module tb_co2_level_filter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic [9:0] sample_data = '0;
  logic [7:0] co2_level;
  logic       level_valid;
  logic       window_full;
  logic       sensor_fault;

  int n_checks = 0;
  int n_fail   = 0;

  co2_level_filter #(
    .SAMPLE_W(10),
    .LOG2_WIN(2),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .co2_level   (co2_level),
    .level_valid (level_valid),
    .window_full (window_full),
    .sensor_fault(sensor_fault)
  );

  always #5 clk = ~clk;

  // Apply inputs for one edge, then wait until 1ns after that edge.
  task automatic cyc(input logic v, input logic [9:0] d, input logic r);
    sample_valid = v;
    sample_data  = d;
    reset        = r;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    reset        = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1'b0, 10'd0, 1'b1);
    cyc(1'b1, 10'd999, 1'b1);
    n_checks++;
    if (co2_level !== 8'd0) begin
      n_fail++; $display("FAIL reset_co2 got=%0d exp=0", co2_level);
    end
    n_checks++;
    if (level_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_lv got=%b exp=0", level_valid);
    end
    n_checks++;
    if (window_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_wf got=%b exp=0", window_full);
    end
    n_checks++;
    if (sensor_fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_sf got=%b exp=0", sensor_fault);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 10'd400, 1'b0);
      n_checks++;
      if (level_valid !== 1'b0 || window_full !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_early%0d lv=%b wf=%b exp lv=0 wf=0", i, level_valid, window_full);
      end
    end
    cyc(1'b1, 10'd400, 1'b0);
    n_checks++;
    if (level_valid !== 1'b1) begin
      n_fail++; $display("FAIL fill_lv got=%b exp=1", level_valid);
    end
    n_checks++;
    if (co2_level !== 8'd100) begin
      n_fail++; $display("FAIL fill_co2 got=%0d exp=100", co2_level);
    end
    n_checks++;
    if (window_full !== 1'b1) begin
      n_fail++; $display("FAIL fill_wf got=%b exp=1", window_full);
    end
  endtask

  task automatic test_slide();
    cyc(1'b1, 10'd800, 1'b0);
    n_checks++;
    if (co2_level !== 8'd125 || level_valid !== 1'b1) begin
      n_fail++; $display("FAIL slide co2=%0d lv=%b exp co2=125 lv=1", co2_level, level_valid);
    end
    cyc(1'b0, 10'd0, 1'b0);
    n_checks++;
    if (co2_level !== 8'd125 || level_valid !== 1'b0) begin
      n_fail++; $display("FAIL slide_hold co2=%0d lv=%b exp co2=125 lv=0", co2_level, level_valid);
    end
  endtask

  task automatic test_full_scale();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'd191, 8'd127, 8'd63, 8'd0};
    for (int i = 0; i < 4; i++) cyc(1'b1, 10'd1023, 1'b0);
    n_checks++;
    if (co2_level !== 8'd255) begin
      n_fail++; $display("FAIL full_scale got=%0d exp=255", co2_level);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 10'd0, 1'b0);
      n_checks++;
      if (co2_level !== exp_seq[i] || level_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL drain%0d co2=%0d lv=%b exp co2=%0d lv=1", i, co2_level, level_valid,
                 exp_seq[i]);
      end
    end
  endtask

`ifdef CO2_FAULT_TIMEOUT_EN
  task automatic test_timeout();
    // sum = 400 -> avg 100 -> co2 25
    cyc(1'b1, 10'd400, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 10'd0, 1'b0);
    n_checks++;
    if (sensor_fault !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early got=%b exp=0", sensor_fault);
    end
    cyc(1'b0, 10'd0, 1'b0);
    n_checks++;
    if (sensor_fault !== 1'b1) begin
      n_fail++; $display("FAIL timeout_fault got=%b exp=1", sensor_fault);
    end
    n_checks++;
    if (co2_level !== 8'd25 || level_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_hold co2=%0d lv=%b exp co2=25 lv=0", co2_level, level_valid);
    end
  endtask

  task automatic test_fault_recovery();
    cyc(1'b1, 10'd200, 1'b0);
    n_checks++;
    if (sensor_fault !== 1'b0 || window_full !== 1'b0 || level_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL recover_first sf=%b wf=%b lv=%b exp 0 0 0", sensor_fault, window_full,
               level_valid);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 10'd200, 1'b0);
      n_checks++;
      if (level_valid !== 1'b0) begin
        n_fail++; $display("FAIL recover_mid%0d lv=%b exp=0", i, level_valid);
      end
    end
    cyc(1'b1, 10'd200, 1'b0);
    n_checks++;
    if (level_valid !== 1'b1 || co2_level !== 8'd50 || window_full !== 1'b1) begin
      n_fail++;
      $display("FAIL recover_last lv=%b co2=%0d wf=%b exp lv=1 co2=50 wf=1", level_valid,
               co2_level, window_full);
    end
  endtask

  task automatic test_timeout_boundary();
    for (int i = 0; i < 15; i++) cyc(1'b0, 10'd0, 1'b0);
    cyc(1'b1, 10'd200, 1'b0);
    n_checks++;
    if (sensor_fault !== 1'b0 || level_valid !== 1'b1 || co2_level !== 8'd50) begin
      n_fail++;
      $display("FAIL boundary sf=%b lv=%b co2=%0d exp sf=0 lv=1 co2=50", sensor_fault,
               level_valid, co2_level);
    end
    for (int i = 0; i < 15; i++) cyc(1'b0, 10'd0, 1'b0);
    n_checks++;
    if (sensor_fault !== 1'b0) begin
      n_fail++; $display("FAIL boundary_rearm got=%b exp=0", sensor_fault);
    end
  endtask
`else
  task automatic test_no_fault();
    bit seen_fault = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      cyc(1'b0, 10'd0, 1'b0);
      if (sensor_fault !== 1'b0) seen_fault = 1'b1;
    end
    n_checks++;
    if (seen_fault) begin
      n_fail++; $display("FAIL no_fault sensor_fault seen=1 exp=0");
    end
    n_checks++;
    if (co2_level !== 8'd25 || window_full !== 1'b1) begin
      n_fail++; $display("FAIL no_fault_hold co2=%0d wf=%b exp co2=25 wf=1", co2_level, window_full);
    end
  endtask
`endif

  task automatic test_reset_mid_run();
    cyc(1'b1, 10'd1000, 1'b1);
    n_checks++;
    if (co2_level !== 8'd0 || level_valid !== 1'b0 || window_full !== 1'b0 ||
        sensor_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset co2=%0d lv=%b wf=%b sf=%b exp all 0", co2_level, level_valid,
               window_full, sensor_fault);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 10'd100, 1'b0);
      n_checks++;
      if (level_valid !== 1'b0 || window_full !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_fill%0d lv=%b wf=%b exp 0 0", i, level_valid, window_full);
      end
    end
    cyc(1'b1, 10'd100, 1'b0);
    n_checks++;
    if (level_valid !== 1'b1 || co2_level !== 8'd25) begin
      n_fail++;
      $display("FAIL midreset_done lv=%b co2=%0d exp lv=1 co2=25", level_valid, co2_level);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_slide();
    test_full_scale();
`ifdef CO2_FAULT_TIMEOUT_EN
    test_timeout();
    test_fault_recovery();
    test_timeout_boundary();
    test_reset_mid_run();
`else
    test_reset_mid_run();
    test_no_fault();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
